// File: rtl/bus_memory.sv
// bus_memory: wait-stated single-port word memory for the core's external bus; BUS_MEMORY_RANGE_CHECK_EN enables out-of-range detection
module bus_memory #(
    parameter int unsigned DEPTH      = 4096,
    parameter logic [31:0] BASE       = 32'h0000_0000,
    parameter int unsigned FETCH_WAIT = 0,
    parameter int unsigned DATA_WAIT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ext_valid,
    input  logic        ext_instruction,
    input  logic [31:0] ext_address,
    input  logic [31:0] ext_write_data,
    input  logic [3:0]  ext_write_strobe,
    output logic        ext_ready,
    output logic [31:0] ext_read_data,
    output logic        range_error
);
    localparam int AW = $clog2(DEPTH);
`ifdef BUS_MEMORY_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_next;
    logic [31:0] mem [DEPTH];
    logic [31:0] offset, lat_wdata;
    logic [AW-1:0] idx, lat_idx, rd_idx;
    logic [3:0] lat_strobe, cnt, cnt_next, load_cnt;
    logic oor, lat_oor, lat_instr, match, bad, unused;
    assign offset = ext_address - BASE;
    assign idx = offset[AW+1:2];
    // BASE is 4*DEPTH aligned, so a wrapped offset catches addresses below BASE too
    assign oor = (offset >> 2) >= 32'(DEPTH);
    assign unused = ^offset[1:0];
    assign load_cnt = ext_instruction ? 4'(FETCH_WAIT) : 4'(DATA_WAIT);
    assign match = ext_valid && ext_instruction == lat_instr && idx == lat_idx &&
                   ext_write_strobe == lat_strobe && ext_write_data == lat_wdata &&
                   (!RANGE_EN || oor == lat_oor);
    assign rd_idx = state == IDLE ? idx : lat_idx;
    assign bad = RANGE_EN && (state == IDLE ? oor : lat_oor);
    always_comb begin
        state_next = state;
        cnt_next = cnt;
        case (state)
            IDLE: if (ext_valid) begin
                cnt_next = load_cnt;
                state_next = load_cnt == 4'd0 ? RESP : WAIT;
            end
            WAIT: begin
                cnt_next = match ? cnt - 4'd1 : 4'd0;
                state_next = !match ? IDLE : cnt == 4'd1 ? RESP : WAIT;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 4'd0;
            ext_ready <= 1'b0;
            ext_read_data <= 32'd0;
            range_error <= 1'b0;
        end else begin
            state <= state_next;
            cnt <= cnt_next;
            ext_ready <= state_next == RESP;
            if (state_next == RESP) begin
                ext_read_data <= bad ? 32'd0 : mem[rd_idx];
                range_error <= range_error | bad;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (state == IDLE && ext_valid) begin
            lat_instr <= ext_instruction;
            lat_idx <= idx;
            lat_strobe <= ext_write_strobe;
            lat_wdata <= ext_write_data;
            lat_oor <= oor;
        end
    end
    // lanes commit on the edge leaving RESP, after the old word was already returned
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && !(RANGE_EN && lat_oor))
            for (int i = 0; i < 4; i++)
                if (lat_strobe[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
    end
endmodule

// File: doc/bus_memory.md
# bus_memory

Single-port word memory that answers the core's external bus: it accepts instruction fetches and data loads/stores, inserts a programmable number of wait states, then returns one `ext_ready` pulse with read data. It sits on the far side of the core's bus adapter and serves as the simulation and FPGA main memory. Byte strobes give sub-word stores. Wait-state counts differ for fetch and data so the bench can exercise pipeline stalls.

## Interface
- `DEPTH`, default 4096: memory size in 32-bit words; power of two.
- `BASE`, default 32'h0000_0000: byte address of word 0; `4*DEPTH`-aligned.
- `FETCH_WAIT`, default 0: wait cycles inserted for `ext_instruction=1` requests; 0..15.
- `DATA_WAIT`, default 1: wait cycles inserted for data requests; 0..15.

- `clk` input 1: clock; all logic on rising edge. One clock; reset is synchronous and active-high.
- `reset` input 1: synchronous, active-high reset.
- `ext_valid` input 1: request present.
- `ext_instruction` input 1: 1 = fetch, 0 = data access.
- `ext_address` input 32: byte address; bits [1:0] ignored.
- `ext_write_data` input 32: store data, already lane-aligned.
- `ext_write_strobe` input 4: byte enables; 0 = read.
- `ext_ready` output 1: one-cycle completion pulse.
- `ext_read_data` output 32: word read; valid only while `ext_ready`=1.
- `range_error` output 1: sticky out-of-range flag; see Configuration.

## Operation
- States: IDLE, WAIT, RESP. Latched request: `{instruction, word index, strobe, write_data}`.
- IDLE: if `ext_valid`, latch the request and load the counter with `FETCH_WAIT` or `DATA_WAIT`. Go to WAIT if the count is nonzero, else RESP. If `ext_valid`=0, stay in IDLE.
- WAIT: each cycle, compare the live inputs with the latched request.
  - Any mismatch, or `ext_valid`=0: abort to IDLE. No write, no `ext_ready`.
  - Otherwise decrement the counter; go to RESP on the cycle it reaches 0.
- On the edge entering RESP, `ext_read_data` is registered from the latched word index. A store's response therefore returns the old word.
- RESP: `ext_ready`=1 for exactly one cycle. At the edge ending RESP, each byte lane whose latched strobe bit is set is written; then go to IDLE. Inputs are not re-checked in RESP.
- Word index is `(ext_address - BASE) >> 2`, truncated to log2(DEPTH) bits; addresses outside the range wrap unless range checking is compiled in.
- Strobe patterns are not validated; any 4-bit mask writes exactly the selected lanes.

## Timing
- Reset state: IDLE. `ext_ready`=0, `ext_read_data`=0, `range_error`=0, counter=0. Memory contents are not reset.
- Accept in cycle T (IDLE, `ext_valid`=1) with wait W: `ext_ready` is high in cycle T+1+W.
- Back-to-back throughput is one request per W+2 cycles, because RESP is always followed by an IDLE accept cycle.
- `ext_ready` and `ext_read_data` are registered; neither has a combinational path from the inputs.
- Reset asserted in WAIT or RESP: return to IDLE next edge. A pending write is dropped and `ext_ready` is forced to 0 that edge.
- An abort in WAIT costs one IDLE cycle, then the new request is accepted.

## Configuration
- `BUS_MEMORY_RANGE_CHECK_EN` defined: requests with an address below `BASE` or at/above `BASE+4*DEPTH` still complete with normal latency.
  - They return `ext_read_data`=0 and perform no write.
  - They set `range_error`=1 at the edge entering RESP; it holds until `reset`.
- Not defined: addresses wrap modulo DEPTH words, and `range_error` is tied to 0.

## Test plan
- Reset, then fetch 0x0000_0010 with FETCH_WAIT=0 and word 4 preloaded to 0x1234_5678: accept in cycle T, `ext_ready`=1 with data 0x1234_5678 in T+1 only.
- DATA_WAIT=3, store 0xAABB_CCDD with strobe 4'b0100 to a word holding 0x1111_1111: `ext_ready` in T+4 with read data 0x1111_1111, then a read returns 0x11BB_1111.
- Abort: start a data read with DATA_WAIT=3, change `ext_address` in the second WAIT cycle: no `ext_ready` for the first request; the new request is accepted one cycle later and completes 4 cycles after its accept.
- Reset mid-store during RESP: the word is unchanged afterwards; `ext_ready` is 0 the cycle after reset and the state is IDLE.
- With the macro, read 0x0000_4000 (DEPTH=4096): data 0 and `range_error`=1, sticky until reset. Without the macro, the same read returns word 0.
